// File: rtl/dcim_gctrl_mp.sv
// -----------------------------------------------------------------------------
// dcim_gctrl_mp
//   Global controller for a digital compute-in-memory macro with multi-precision
//   bit-serial inputs. Each accepted operation sweeps a bit-serial cycle index
//   (sel) over N = 4/8/12/24 cycles chosen by the input precision, flags the
//   leading signed cycles, emits accumulator first/last strobes delayed by the
//   array-to-accumulator latency, and rotates NBANK weight banks so one bank is
//   used for MAC while the next is open for weight writes.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start_valid/start_ready operation request handshake
//   inwidth                 input precision (0=4b, 1=8b, 2=12b, 3=24b)
//   wwidth, wwidth_q        weight precision in / latched copy out
//   sign_en                 enable signed leading cycles for this operation
//   abort                   synchronous cancel of the running operation
//   sel, sel_valid          bit-serial cycle index to the row driver
//   signed_op               current sel cycle is a signed cycle
//   start_acc, acc_last     accumulator first / last cycle strobes
//   mac_bank, write_bank    bank in use for MAC / bank open for weight write
//   busy                    controller not idle
//   op_done                 one-cycle completion pulse
// -----------------------------------------------------------------------------
module dcim_gctrl_mp #(
    parameter int SEL_WIDTH     = 5,
    parameter int NBANK         = 2,
    parameter int ACC_DELAY     = 3,
    parameter int SIGNED_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [1:0]               inwidth,
    input  logic [1:0]               wwidth,
    input  logic                     sign_en,
    input  logic                     abort,
    output logic [SEL_WIDTH-1:0]     sel,
    output logic                     sel_valid,
    output logic                     signed_op,
    output logic                     start_acc,
    output logic                     acc_last,
    output logic [$clog2(NBANK)-1:0] mac_bank,
    output logic [$clog2(NBANK)-1:0] write_bank,
    output logic [1:0]               wwidth_q,
    output logic                     busy,
    output logic                     op_done
);

    localparam int BANK_W = $clog2(NBANK);

    // Signed-cycle threshold clamped to the range a sel value can reach, so the
    // compare below is a plain unsigned compare one bit wider than sel.
    localparam int SC_CAP = (SIGNED_CYCLES < 0) ? 0 :
                            (SIGNED_CYCLES > (1 << SEL_WIDTH)) ? (1 << SEL_WIDTH) :
                            SIGNED_CYCLES;
    localparam logic [SEL_WIDTH:0] SIGNED_LIM = (SEL_WIDTH + 1)'(SC_CAP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   sel_q;
    logic [SEL_WIDTH-1:0]   last_q;        // N-1 of the running operation
    logic                   sign_en_q;
    logic [BANK_W-1:0]      mac_bank_q;
    logic [BANK_W-1:0]      write_bank_q;
    logic                   op_done_q;
    logic [ACC_DELAY-1:0]   first_strb_p;  // bit i = strobe delayed i+1 cycles
    logic [ACC_DELAY-1:0]   last_strb_p;

    logic accept;
    logic sel_at_last;
    logic flush;
    logic first_in;
    logic last_in;

    // Last sel index for each input precision.
    function automatic logic [SEL_WIDTH-1:0] last_index(input logic [1:0] w);
        case (w)
            2'd0:    return SEL_WIDTH'(3);
            2'd1:    return SEL_WIDTH'(7);
            2'd2:    return SEL_WIDTH'(11);
            default: return SEL_WIDTH'(23);
        endcase
    endfunction

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NBANK - 1)) ? '0 : b + BANK_W'(1);
    endfunction

    assign start_ready = (state_q == IDLE) && !abort;
    assign accept      = start_valid && start_ready;
    assign busy        = (state_q != IDLE);
    assign sel_valid   = (state_q == RUN);
    assign sel         = sel_q;
    assign sel_at_last = (sel_q == last_q);
    assign flush       = abort && busy;
    assign signed_op   = sel_valid && sign_en_q && ({1'b0, sel_q} < SIGNED_LIM);
    assign first_in    = sel_valid && (sel_q == '0);
    assign last_in     = sel_valid && sel_at_last;
    assign start_acc   = first_strb_p[ACC_DELAY-1];
    assign acc_last    = last_strb_p[ACC_DELAY-1];
    assign mac_bank    = mac_bank_q;
    assign write_bank  = write_bank_q;
    assign op_done     = op_done_q;

    // DRAIN needs no counter of its own: the delayed last strobe arrives exactly
    // ACC_DELAY cycles after the final sel cycle, which is when draining ends.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (abort) state_d = IDLE;
                     else if (sel_at_last) state_d = DRAIN;
            DRAIN:   if (abort || acc_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_q       <= '0;
            sign_en_q    <= 1'b0;
            wwidth_q     <= 2'd0;
            mac_bank_q   <= BANK_W'(NBANK - 1);
            write_bank_q <= '0;
            op_done_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            // sel only counts inside RUN and returns to 0 on any exit.
            if ((state_q == RUN) && !abort && !sel_at_last) begin
                sel_q <= sel_q + SEL_WIDTH'(1);
            end else begin
                sel_q <= '0;
            end

            if (accept) begin
                last_q       <= last_index(inwidth);
                sign_en_q    <= sign_en;
                wwidth_q     <= wwidth;
                mac_bank_q   <= write_bank_q;
                write_bank_q <= next_bank(write_bank_q);
            end

            op_done_q <= acc_last && !flush;
        end
    end

    // ---- accumulator strobe delay line: ACC_DELAY stages ----
    if (ACC_DELAY == 1) begin : g_strb_d1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                first_strb_p <= '0;
                last_strb_p  <= '0;
            end else begin
                first_strb_p <= flush ? 1'b0 : first_in;
                last_strb_p  <= flush ? 1'b0 : last_in;
            end
        end
    end else begin : g_strb_dn
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                first_strb_p <= '0;
                last_strb_p  <= '0;
            end else if (flush) begin
                first_strb_p <= '0;
                last_strb_p  <= '0;
            end else begin
                first_strb_p <= {first_strb_p[ACC_DELAY-2:0], first_in};
                last_strb_p  <= {last_strb_p[ACC_DELAY-2:0], last_in};
            end
        end
    end

endmodule

// File: tb/tb_dcim_gctrl_mp.sv
// -----------------------------------------------------------------------------
// tb_dcim_gctrl_mp
//   Scoreboard bench for dcim_gctrl_mp (NBANK=3, other parameters default).
//   The driver decides from a timeline model which requests are accepted and,
//   for each accepted operation, pushes the expected sel beats and strobe
//   cycles into queues; a negedge monitor pops and compares whenever the DUT
//   presents sel_valid or a strobe, and also checks busy/start_ready per cycle.
// -----------------------------------------------------------------------------
module tb_dcim_gctrl_mp;

    localparam int SW = 5;
    localparam int NB = 3;
    localparam int D  = 3;
    localparam int SC = 4;

    logic          clk;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [1:0]    inwidth;
    logic [1:0]    wwidth;
    logic          sign_en;
    logic          abort;
    logic [SW-1:0] sel;
    logic          sel_valid;
    logic          signed_op;
    logic          start_acc;
    logic          acc_last;
    logic [1:0]    mac_bank;
    logic [1:0]    write_bank;
    logic [1:0]    wwidth_q;
    logic          busy;
    logic          op_done;

    dcim_gctrl_mp #(
        .SEL_WIDTH    (SW),
        .NBANK        (NB),
        .ACC_DELAY    (D),
        .SIGNED_CYCLES(SC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .inwidth    (inwidth),
        .wwidth     (wwidth),
        .sign_en    (sign_en),
        .abort      (abort),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .signed_op  (signed_op),
        .start_acc  (start_acc),
        .acc_last   (acc_last),
        .mac_bank   (mac_bank),
        .write_bank (write_bank),
        .wwidth_q   (wwidth_q),
        .busy       (busy),
        .op_done    (op_done)
    );

    typedef struct {
        int cyc;
        int sel;
        int sgn;
        int mac;
        int wb;
        int ww;
    } beat_t;

    beat_t exp_beats[$];
    int    exp_strb[3][$];          // 0: start_acc, 1: acc_last, 2: op_done
    string snm[3] = '{"start_acc", "acc_last", "op_done"};

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 0;

    // Timeline model: busy during [busy_from, idle_from).
    int busy_from = 0;
    int idle_from = 0;
    int m_wb  = 0;
    int m_mac = NB - 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int op_len(input logic [1:0] w);
        case (w)
            2'd0:    return 4;
            2'd1:    return 8;
            2'd2:    return 12;
            default: return 24;
        endcase
    endfunction

    task automatic model_step(input bit sv, input logic [1:0] iw, input logic [1:0] ww,
                              input bit se, input bit ab);
        int    c;
        int    n;
        bit    bsy;
        beat_t b;
        c   = cyc;
        bsy = (c >= busy_from) && (c < idle_from);
        if (ab && bsy) begin
            // Everything scheduled after the abort cycle disappears.
            while (exp_beats.size() > 0 && exp_beats[exp_beats.size()-1].cyc > c)
                exp_beats.delete(exp_beats.size() - 1);
            for (int k = 0; k < 3; k++)
                while (exp_strb[k].size() > 0 && exp_strb[k][exp_strb[k].size()-1] > c)
                    exp_strb[k].delete(exp_strb[k].size() - 1);
            idle_from = c + 1;
        end else if (sv && !ab && !bsy) begin
            n     = op_len(iw);
            m_mac = m_wb;
            m_wb  = (m_wb + 1) % NB;
            for (int k = 0; k < n; k++) begin
                b.cyc = c + 1 + k;
                b.sel = k;
                b.sgn = (se && k < SC) ? 1 : 0;
                b.mac = m_mac;
                b.wb  = m_wb;
                b.ww  = int'(ww);
                exp_beats.push_back(b);
            end
            exp_strb[0].push_back(c + 1 + D);
            exp_strb[1].push_back(c + n + D);
            exp_strb[2].push_back(c + n + D + 1);
            busy_from = c + 1;
            idle_from = c + n + D + 1;
        end
    endtask

    // Called just after a rising edge; drives one cycle of inputs.
    task automatic step(input bit sv, input logic [1:0] iw, input logic [1:0] ww,
                        input bit se, input bit ab);
        start_valid = sv;
        inwidth     = iw;
        wwidth      = ww;
        sign_en     = se;
        abort       = ab;
        model_step(sv, iw, ww, se, ab);
        @(posedge clk);
        #1;
    endtask

    task automatic step_quiet();
        step(1'b0, 2'($urandom), 2'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic run_to_idle();
        int guard;
        guard = 0;
        while (cyc < idle_from && guard < 200) begin
            step_quiet();
            guard++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sel"},        int'(sel),        0);
        chk({tag, "_sel_valid"},  int'(sel_valid),  0);
        chk({tag, "_signed_op"},  int'(signed_op),  0);
        chk({tag, "_start_acc"},  int'(start_acc),  0);
        chk({tag, "_acc_last"},   int'(acc_last),   0);
        chk({tag, "_op_done"},    int'(op_done),    0);
        chk({tag, "_busy"},       int'(busy),       0);
        chk({tag, "_write_bank"}, int'(write_bank), 0);
        chk({tag, "_mac_bank"},   int'(mac_bank),   NB - 1);
        chk({tag, "_wwidth_q"},   int'(wwidth_q),   0);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin : mon
        int         c;
        bit         eb;
        logic [2:0] st;
        beat_t      b;
        if (rst_n && mon_en) begin
            c  = cyc;
            eb = (c >= busy_from) && (c < idle_from);
            chk("busy", int'(busy), int'(eb));
            chk("start_ready", int'(start_ready), int'(!eb && !abort));

            while (exp_beats.size() > 0 && exp_beats[0].cyc < c) begin
                b = exp_beats.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL sel_missing: sel %0d due at cycle %0d not seen by cycle %0d",
                         b.sel, b.cyc, c);
            end
            if (sel_valid) begin
                if (exp_beats.size() == 0 || exp_beats[0].cyc != c) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sel_valid_unexpected at cycle %0d: got 1, expected 0", c);
                end else begin
                    b = exp_beats.pop_front();
                    chk("sel",        int'(sel),        b.sel);
                    chk("signed_op",  int'(signed_op),  b.sgn);
                    chk("mac_bank",   int'(mac_bank),   b.mac);
                    chk("write_bank", int'(write_bank), b.wb);
                    chk("wwidth_q",   int'(wwidth_q),   b.ww);
                end
            end else begin
                chk("sel_idle_zero",    int'(sel),       0);
                chk("signed_op_idle",   int'(signed_op), 0);
            end

            st = {op_done, acc_last, start_acc};
            for (int k = 0; k < 3; k++) begin
                while (exp_strb[k].size() > 0 && exp_strb[k][0] < c) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s_missing: due at cycle %0d not seen by cycle %0d",
                             snm[k], exp_strb[k][0], c);
                    exp_strb[k].delete(0);
                end
                if (st[k]) begin
                    if (exp_strb[k].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL %s_unexpected at cycle %0d: got 1, expected 0", snm[k], c);
                    end else begin
                        chk({snm[k], "_cycle"}, c, exp_strb[k][0]);
                        if (exp_strb[k][0] == c) exp_strb[k].delete(0);
                    end
                end
            end
        end
    end

    initial begin
        int a;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        inwidth     = 2'd0;
        wwidth      = 2'd0;
        sign_en     = 1'b0;
        abort       = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check_reset_values("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) step_quiet();

        // Three back-to-back 4-cycle ops with start_valid held: banks 0,1,2.
        repeat (24) step(1'b1, 2'd0, 2'($urandom), 1'($urandom), 1'b0);
        run_to_idle();
        repeat (2) step_quiet();

        // 12-cycle signed op; inputs scrambled while it runs.
        step(1'b1, 2'd2, 2'd1, 1'b1, 1'b0);
        run_to_idle();

        // 4-cycle unsigned op, then the 24-cycle op.
        step(1'b1, 2'd0, 2'd3, 1'b0, 1'b0);
        run_to_idle();
        step(1'b1, 2'd3, 2'd2, 1'b1, 1'b0);
        run_to_idle();

        // Abort while sel==5, then a fresh op on the following bank.
        step(1'b1, 2'd1, 2'd1, 1'b1, 1'b0);
        a = cyc - 1;
        while (cyc < a + 6) step_quiet();
        step(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        step_quiet();
        step(1'b1, 2'd0, 2'd2, 1'b1, 1'b0);
        run_to_idle();

        // Abort in the accept cycle of an idle controller blocks acceptance.
        step(1'b1, 2'd1, 2'd1, 1'b1, 1'b1);
        step_quiet();

        // start_valid held through an op with inwidth toggling.
        step(1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
        repeat (10) step(1'b1, 2'($urandom), 2'($urandom), 1'($urandom), 1'b0);
        run_to_idle();

        // Asynchronous reset while sel==7.
        step(1'b1, 2'd3, 2'd2, 1'b1, 1'b0);
        a = cyc - 1;
        while (cyc < a + 8) step_quiet();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        exp_beats.delete();
        for (int k = 0; k < 3; k++) exp_strb[k].delete();
        busy_from = 0;
        idle_from = 0;
        m_wb      = 0;
        m_mac     = NB - 1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic with occasional aborts.
        repeat (400)
            step(($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom),
                 1'($urandom), ($urandom_range(0, 29) == 0));
        run_to_idle();
        repeat (4) step_quiet();

        chk("beats_left",      exp_beats.size(),   0);
        chk("start_acc_left",  exp_strb[0].size(), 0);
        chk("acc_last_left",   exp_strb[1].size(), 0);
        chk("op_done_left",    exp_strb[2].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcim_gctrl_mp.md
DCIM_GCTRL_MP -- requirements
Module: dcim_gctrl_mp

Interface
REQ-001 Parameter SEL_WIDTH, default 5, sel counter width; SHALL be >= 5.
REQ-002 Parameter NBANK, default 2, number of rotating weight banks (ping-pong generalised); SHALL be >= 2.
REQ-003 Parameter ACC_DELAY, default 3, array-to-accumulator pipeline latency in cycles; SHALL be >= 1.
REQ-004 Parameter SIGNED_CYCLES, default 4, number of leading signed bit-serial cycles.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start_valid  input  1  operation request.
REQ-008 start_ready  output  1  high when a request can be accepted.
REQ-009 inwidth  input  2  input precision: 0=4b, 1=8b, 2=12b, 3=24b.
REQ-010 wwidth  input  2  weight precision, latched and forwarded.
REQ-011 sign_en  input  1  enables signed cycles for this operation.
REQ-012 abort  input  1  synchronous cancel of the current operation.
REQ-013 sel  output  SEL_WIDTH  bit-serial cycle index to the row driver.
REQ-014 sel_valid  output  1  sel is meaningful this cycle.
REQ-015 signed_op  output  1  current sel cycle is signed.
REQ-016 start_acc / acc_last  output  1 each  accumulator first/last-cycle strobes.
REQ-017 mac_bank / write_bank  output  clog2(NBANK) each  bank used for MAC / open for weight write.
REQ-018 wwidth_q  output  2  latched weight precision.
REQ-019 busy  output  1  high in any non-IDLE state.
REQ-020 op_done  output  1  one-cycle completion pulse.

Function
REQ-021 States IDLE, RUN, DRAIN; start_ready = (state==IDLE) && !abort.
REQ-022 Accept = start_valid && start_ready; on accept: latch inwidth, wwidth, sign_en; N = 4/8/12/24 per inwidth; mac_bank <= write_bank; write_bank <= (write_bank+1) mod NBANK; state -> RUN.
REQ-023 inwidth/wwidth/sign_en changes after accept SHALL NOT affect the running operation.
REQ-024 RUN: sel_valid=1 for exactly N consecutive cycles starting the cycle after accept; sel = 0,1,...,N-1; after sel==N-1, state -> DRAIN.
REQ-025 sel SHALL hold 0 whenever sel_valid=0.
REQ-026 signed_op = sel_valid && sign_en_q && (sel < SIGNED_CYCLES); for N <= SIGNED_CYCLES every cycle is signed.
REQ-027 start_acc SHALL pulse exactly ACC_DELAY cycles after the sel==0 cycle; acc_last exactly ACC_DELAY cycles after the sel==N-1 cycle (both may fall in RUN or DRAIN).
REQ-028 DRAIN SHALL last ACC_DELAY cycles; op_done pulses the cycle after acc_last, coincident with return to IDLE (start_ready=1).
REQ-029 Back-to-back: an accept in the op_done cycle SHALL start RUN next cycle with no gap beyond REQ-024.
REQ-030 abort in RUN or DRAIN: next cycle state=IDLE, sel_valid, signed_op, start_acc, acc_last, op_done all 0, pending strobes flushed; bank pointers keep their advanced values.
REQ-031 abort in IDLE SHALL be ignored and SHALL block acceptance that cycle.
REQ-032 start_valid while busy SHALL be ignored (not queued).

Reset
REQ-033 On rst_n low: state=IDLE, sel=0, sel_valid=0, start_acc=0, acc_last=0, op_done=0, busy=0, write_bank=0, mac_bank=NBANK-1, wwidth_q=0, latched sign_en=0, strobe pipeline cleared.
REQ-034 Reset asserted mid-operation SHALL immediately force REQ-033 values; no op_done.

Verification
REQ-035 Defaults, inwidth=2, sign_en=1, accept at cycle 0 -> sel 0..11 cycles 1-12, signed_op cycles 1-4, start_acc cycle 4, acc_last cycle 15, op_done cycle 16.
REQ-036 Three back-to-back ops, NBANK=3 -> mac_bank 0,1,2; write_bank 1,2,0; no idle cycle between ops' sel_valid windows beyond the ACC_DELAY+1 drain.
REQ-037 inwidth=0, SIGNED_CYCLES=4, sign_en=0 -> 4 sel cycles, signed_op never high; then inwidth=3 -> 24 sel cycles, sel max 23.
REQ-038 abort at sel==5 -> next cycle busy=0, no acc_last/op_done; following op uses next bank.
REQ-039 rst_n low at sel==7 -> all outputs at reset values asynchronously, banks back to write_bank=0, mac_bank=NBANK-1.
REQ-040 start_valid held high while busy, and inwidth toggled mid-op -> single op, length per latched inwidth.
